seq_shift_add_multiplier: RTL and testbench



---
 rtl/seq_shift_add_multiplier_pkg.sv | 20 ++
 rtl/seq_shift_add_multiplier_shift_add_datapath.sv | 56 +++++
 rtl/seq_shift_add_multiplier.sv | 77 +++++++
 tb/tb_seq_shift_add_multiplier.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared constants for the shift-and-add multiplier: default operand width,
// counter sizing and the controller state encoding.
package seq_shift_add_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must be able to represent WIDTH itself, hence the +1.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int COUNT_W = count_width(DEFAULT_WIDTH);

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/seq_shift_add_multiplier_shift_add_datapath.sv
// Operand registers, accumulator and step counter for the radix-2 multiplier.
// The controller drives load/step; product shows the accumulator after this step.
module shift_add_datapath
    import seq_shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = count_width(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   v1,
    input  logic [WIDTH-1:0]   v2,
    output logic               count_done,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplr;
    logic [2*WIDTH:0]   acc;
    logic [CW-1:0]      count;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH:0]   acc_next;

    // The top bit of acc is always zero after a shift, so the upper sum
    // cannot overflow its WIDTH+1 bits.
    always_comb begin
        addend    = mplr[0] ? {1'b0, mcand} : '0;
        upper_sum = acc[2*WIDTH:WIDTH] + addend;
        acc_next  = {upper_sum, acc[WIDTH-1:0]} >> 1;
    end

    assign product    = acc_next[2*WIDTH-1:0];
    assign count_done = step && (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            count <= '0;
        end else if (load) begin
            mcand <= v1;
            mplr  <= v2;
            acc   <= '0;
            count <= '0;
        end else if (step) begin
            acc   <= acc_next;
            mplr  <= mplr >> 1;
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned multiplier behind a start/ready handshake: one
// partial-product step per clock, product registered on the final step.
module seq_shift_add_multiplier
    import seq_shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   v1,
    input  logic [WIDTH-1:0]   v2,
    output logic [2*WIDTH-1:0] out,
    output logic               ready
);

    localparam int CW = count_width(WIDTH);

    state_t             state;
    logic               load;
    logic               step;
    logic               count_done;
    logic [2*WIDTH-1:0] product;

    // start is only honoured when no operation is in flight.
    assign load = ((state == IDLE) || (state == DONE)) && start;
    assign step = (state == BUSY);

    shift_add_datapath #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .step       (step),
        .v1         (v1),
        .v2         (v2),
        .count_done (count_done),
        .product    (product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            out   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUSY;
                        ready <= 1'b0;
                    end
                end
                BUSY: begin
                    if (count_done) begin
                        state <= DONE;
                        out   <= product;
                        ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state <= BUSY;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier: stimulus pushes v1*v2 into a
// queue, a monitor pops on each rising ready and checks product and latency.
module tb_seq_shift_add_multiplier;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   v1;
    logic [WIDTH-1:0]   v2;
    logic [2*WIDTH-1:0] out;
    logic               ready;

    typedef struct {
        logic [2*WIDTH-1:0] product;
        int                 loadEdge;
    } exp_t;

    exp_t sbQ[$];
    int   cycle    = 0;
    int   checks   = 0;
    int   failures = 0;
    logic prevReady = 1'b0;

    seq_shift_add_multiplier #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .v1    (v1),
        .v2    (v2),
        .out   (out),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference product is plain integer multiplication of the operands.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input int holdCycles, input bit track);
        exp_t e;
        @(posedge clk);
        #1;
        v1    = a;
        v2    = b;
        start = 1'b1;
        if (track) begin
            e.product  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
            e.loadEdge = cycle + 1;
            sbQ.push_back(e);
        end
        repeat (holdCycles) @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone();
        for (int i = 0; i < 40 && sbQ.size() > 0; i++) @(negedge clk);
        if (sbQ.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout: %0d results pending, expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    // Monitor: every rising edge of ready must match the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            prevReady = 1'b0;
        end else begin
            if (ready && !prevReady) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_ready", 1, 0);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    checkOutput("product", out, e.product);
                    checkOutput("latency", cycle - e.loadEdge, WIDTH);
                end
            end
            prevReady = ready;
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        v1    = '0;
        v2    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out", out, 0);
        checkOutput("reset_ready", ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic product with start held across several edges.
        applyStimulus(8'd12, 8'd167, 2, 1'b1);
        waitDone();
        repeat (5) @(negedge clk);
        checkOutput("hold_out", out, 2004);
        checkOutput("hold_ready", ready, 1);

        // Corner operands.
        applyStimulus(8'd0, 8'd200, 1, 1'b1);
        waitDone();
        applyStimulus(8'd255, 8'd255, 1, 1'b1);
        waitDone();
        applyStimulus(8'd1, 8'd255, 1, 1'b1);
        waitDone();
        applyStimulus(8'd128, 8'd2, 1, 1'b1);
        waitDone();

        // Back-to-back: old product stays visible while busy, ready marks it stale.
        applyStimulus(8'd12, 8'd167, 1, 1'b1);
        waitDone();
        applyStimulus(8'd3, 8'd5, 1, 1'b1);
        checkOutput("b2b_ready_drop", ready, 0);
        checkOutput("b2b_stale_out", out, 2004);
        repeat (3) @(negedge clk);
        checkOutput("b2b_busy_out", out, 2004);
        waitDone();

        // Start pulsed mid-operation must be ignored.
        applyStimulus(8'd12, 8'd167, 1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        v1    = 8'd255;
        v2    = 8'd255;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone();

        // Operands wander while busy; result uses the latched values.
        applyStimulus(8'd200, 8'd77, 1, 1'b1);
        for (int i = 0; i < WIDTH; i++) begin
            @(posedge clk);
            #1;
            v1 = WIDTH'($urandom);
            v2 = WIDTH'($urandom);
        end
        waitDone();

        // Reset mid-operation aborts it.
        applyStimulus(8'd12, 8'd167, 1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_out", out, 0);
        checkOutput("abort_ready", ready, 0);
        rst = 1'b0;
        applyStimulus(8'd12, 8'd167, 1, 1'b1);
        waitDone();

        // Randomized operations.
        for (int n = 0; n < 20; n++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), $urandom_range(1, 3), 1'b1);
            waitDone();
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
